// File: rtl/pow_arbiter.sv
// ---------------------------------------------------------------------------
// pow_arbiter
//
// Round-robin arbiter and sequencer that shares one multi-cycle power unit
// among NUM_REQ requesters. One operand is accepted per grant and issued to
// the unit with a single-cycle valid pulse. The arbiter then waits for the
// unit's result and returns it tagged with the requester index, holding it
// until the consumer accepts. A watchdog abandons the transaction if the unit
// stays silent for TIMEOUT wait cycles.
//
// Ports
//   clk                in   clock, rising edge
//   rst                in   asynchronous active-high reset
//   req_valid          in   [NUM_REQ]        per-requester operand valid (level held)
//   req_data           in   [NUM_REQ*DATA_W] packed operands, channel i at [i*DATA_W +: DATA_W]
//   req_ready          out  [NUM_REQ]        one-hot, one-cycle acceptance pulse
//   pu_data_in         out  [DATA_W]         operand to the power unit
//   pu_data_valid      out  1                one-cycle issue pulse
//   pu_data_out        in   [RES_W]          power unit result
//   pu_data_out_valid  in   1                power unit result pulse
//   resp_valid         out  1                result available
//   resp_data          out  [RES_W]          result, stable while resp_valid
//   resp_id            out  [ID_W]           requester the result belongs to
//   resp_ready         in   1                consumer accepts the result
//   busy               out  1                high whenever not IDLE
//   err_timeout        out  1                one-cycle pulse on watchdog abort
//   err_stray          out  1                one-cycle pulse on a result outside WAIT
// ---------------------------------------------------------------------------
module pow_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 16,
    parameter  int RES_W   = 32,
    parameter  int TIMEOUT = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic signed [DATA_W-1:0]  pu_data_in,
    output logic                      pu_data_valid,
    input  logic signed [RES_W-1:0]   pu_data_out,
    input  logic                      pu_data_out_valid,
    output logic                      resp_valid,
    output logic signed [RES_W-1:0]   resp_data,
    output logic [ID_W-1:0]           resp_id,
    input  logic                      resp_ready,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_stray
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [ID_W-1:0]           r_rr_ptr;
    logic [ID_W-1:0]           r_grant_id;
    logic [CNT_W-1:0]          r_wd;
    logic [NUM_REQ-1:0]        r_req_ready;
    logic signed [DATA_W-1:0]  r_pu_data_in;
    logic                      r_pu_data_valid;
    logic                      r_resp_valid;
    logic signed [RES_W-1:0]   r_resp_data;
    logic [ID_W-1:0]           r_resp_id;
    logic                      r_err_timeout;
    logic                      r_err_stray;

    logic                      w_any;
    logic [ID_W-1:0]           w_win;
    logic [ID_W-1:0]           w_next_ptr;

    // Winner = first asserted request at or above rr_ptr, wrapping around.
    always_comb begin : arb_search
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_win = ID_W'(idx);
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    assign w_next_ptr = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_wd            <= '0;
            r_req_ready     <= '0;
            r_pu_data_in    <= '0;
            r_pu_data_valid <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= '0;
            r_resp_id       <= '0;
            r_err_timeout   <= 1'b0;
            r_err_stray     <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            r_req_ready     <= '0;
            r_pu_data_valid <= 1'b0;
            r_err_timeout   <= 1'b0;
            // A result outside WAIT is flagged and otherwise dropped.
            r_err_stray     <= pu_data_out_valid && (r_state != WAIT);

            case (r_state)
                // Arbitration: latch winner's operand and pre-load the
                // acceptance/issue pulses so they are high during ISSUE.
                IDLE: begin
                    if (w_any) begin
                        r_pu_data_in    <= $signed(req_data[w_win*DATA_W +: DATA_W]);
                        r_grant_id      <= w_win;
                        r_rr_ptr        <= w_next_ptr;
                        r_req_ready     <= NUM_REQ'(1) << w_win;
                        r_pu_data_valid <= 1'b1;
                        r_state         <= ISSUE;
                    end
                end

                // Issue: single cycle, operand on the unit's input.
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end

                // Wait: a result on the last permitted cycle still wins
                // over the watchdog.
                WAIT: begin
                    if (pu_data_out_valid) begin
                        r_resp_data  <= pu_data_out;
                        r_resp_id    <= r_grant_id;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_wd == CNT_W'(TIMEOUT - 1)) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_wd <= r_wd + CNT_W'(1);
                    end
                end

                // Response: hold until the consumer takes it.
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign pu_data_in    = r_pu_data_in;
    assign pu_data_valid = r_pu_data_valid;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_id       = r_resp_id;
    assign err_timeout   = r_err_timeout;
    assign err_stray     = r_err_stray;
    assign busy          = (r_state != IDLE);

endmodule
